// File: rtl/mem_access_pkg.sv
// Shared widths, load/store op codes and the load/store decode helper for the
// memory-access stage.
package mem_access_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_W      = 32;
  localparam int ALU_OP_W   = 8;
  localparam int BE_W       = 4;

  localparam logic [ALU_OP_W-1:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [ALU_OP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [ALU_OP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [ALU_OP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [ALU_OP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [ALU_OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [ALU_OP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [ALU_OP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [ALU_OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } acc_size_e;

  typedef struct packed {
    logic      is_load;
    logic      is_store;
    logic      is_signed;
    acc_size_e size;
  } mem_op_t;

  function automatic mem_op_t decode_op(input logic [ALU_OP_W-1:0] aluop);
    mem_op_t op;
    op = '{is_load: 1'b0, is_store: 1'b0, is_signed: 1'b0, size: SIZE_WORD};
    case (aluop)
      EXE_LB_OP:  op = '{1'b1, 1'b0, 1'b1, SIZE_BYTE};
      EXE_LBU_OP: op = '{1'b1, 1'b0, 1'b0, SIZE_BYTE};
      EXE_LH_OP:  op = '{1'b1, 1'b0, 1'b1, SIZE_HALF};
      EXE_LHU_OP: op = '{1'b1, 1'b0, 1'b0, SIZE_HALF};
      EXE_LW_OP:  op = '{1'b1, 1'b0, 1'b0, SIZE_WORD};
      EXE_SB_OP:  op = '{1'b0, 1'b1, 1'b0, SIZE_BYTE};
      EXE_SH_OP:  op = '{1'b0, 1'b1, 1'b0, SIZE_HALF};
      EXE_SW_OP:  op = '{1'b0, 1'b1, 1'b0, SIZE_WORD};
      default:    op = '{1'b0, 1'b0, 1'b0, SIZE_WORD};
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Big-endian lane logic: byte enables, store-data replication, alignment
// check and load-data extraction/extension. Purely combinational.
module mem_align
  import mem_access_pkg::*;
(
  input  logic [ALU_OP_W-1:0] aluop,
  input  logic [REG_W-1:0]    addr,
  input  logic [REG_W-1:0]    store_data,
  input  logic [REG_W-1:0]    rdata,
  output logic                is_mem,
  output logic                is_load,
  output logic                misaligned,
  output logic [BE_W-1:0]     be,
  output logic [REG_W-1:0]    lane_wdata,
  output logic [REG_W-1:0]    load_data
);

  mem_op_t     op;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    op         = decode_op(aluop);
    is_mem     = op.is_load | op.is_store;
    is_load    = op.is_load;
    misaligned = 1'b0;
    be         = 4'b1111;
    lane_wdata = store_data;
    load_data  = rdata;

    // Lane 0 is the most significant byte (big-endian).
    case (addr[1:0])
      2'd0:    byte_sel = rdata[31:24];
      2'd1:    byte_sel = rdata[23:16];
      2'd2:    byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[15:0] : rdata[31:16];

    case (op.size)
      SIZE_BYTE: begin
        be         = 4'b1000 >> addr[1:0];
        lane_wdata = {4{store_data[7:0]}};
        load_data  = {{24{op.is_signed & byte_sel[7]}}, byte_sel};
      end
      SIZE_HALF: begin
        misaligned = addr[0];
        be         = addr[1] ? 4'b0011 : 4'b1100;
        lane_wdata = {2{store_data[15:0]}};
        load_data  = {{16{op.is_signed & half_sel[15]}}, half_sel};
      end
      default: begin
        misaligned = addr[1] | addr[0];
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: pass-through for ALU ops, bus transaction FSM with timeout for
// loads/stores, and stall/bubble generation toward mem_wb.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [REG_W-1:0]      ex_wdata,
  input  logic [REG_W-1:0]      ex_pc,
  input  logic [ALU_OP_W-1:0]   ex_aluop,
  input  logic [REG_W-1:0]      ex_mem_addr,
  input  logic [REG_W-1:0]      ex_mem_data,
  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [REG_W-1:0]      mem_wdata,
  output logic [REG_W-1:0]      mem_pc,
  output logic [ALU_OP_W-1:0]   mem_aluop,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [BE_W-1:0]       bus_be,
  output logic [REG_W-1:0]      bus_addr,
  output logic [REG_W-1:0]      bus_wdata,
  input  logic                  bus_ack,
  input  logic [REG_W-1:0]      bus_rdata,
  output logic                  stallreq,
  output logic                  addr_err,
  output logic                  bus_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [REG_W-1:0] res_wdata_reg;
  logic             res_wreg_reg;

  logic             is_mem, is_load, misaligned;
  logic [BE_W-1:0]  be;
  logic [REG_W-1:0] lane_wdata, load_data;
  logic             start, timeout_hit;

  mem_align u_align (
    .aluop      (ex_aluop),
    .addr       (ex_mem_addr),
    .store_data (ex_mem_data),
    .rdata      (bus_rdata),
    .is_mem     (is_mem),
    .is_load    (is_load),
    .misaligned (misaligned),
    .be         (be),
    .lane_wdata (lane_wdata),
    .load_data  (load_data)
  );

  assign start       = (state_reg == S_IDLE) && is_mem && !misaligned;
  assign timeout_hit = (state_reg == S_REQ) && !bus_ack && (cnt_reg == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      res_wdata_reg <= '0;
      res_wreg_reg  <= 1'b0;
      bus_req       <= 1'b0;
      bus_we        <= 1'b0;
      bus_be        <= '0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_REQ;
            cnt_reg   <= '0;
            bus_req   <= 1'b1;
            bus_we    <= !is_load;
            bus_be    <= be;
            bus_addr  <= {ex_mem_addr[REG_W-1:2], 2'b00};
            bus_wdata <= lane_wdata;
          end
        end
        S_REQ: begin
          // A late ack on the final counted cycle still completes normally.
          if (bus_ack) begin
            res_wdata_reg <= load_data;
            res_wreg_reg  <= is_load & ex_wreg;
            state_reg     <= S_DONE;
            bus_req       <= 1'b0;
          end else if (cnt_reg == CNT_W'(TIMEOUT)) begin
            res_wreg_reg <= 1'b0;
            state_reg    <= S_DONE;
            bus_req      <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Gated by rst so stall/error flags drop the instant reset is applied.
  assign stallreq = !rst && (start || (state_reg == S_REQ));
  assign addr_err = !rst && (state_reg == S_IDLE) && is_mem && misaligned;
  assign bus_err  = !rst && timeout_hit;

  assign mem_wd    = ex_wd;
  assign mem_pc    = ex_pc;
  assign mem_aluop = ex_aluop;
  assign mem_wdata = (state_reg == S_DONE) ? res_wdata_reg : ex_wdata;

  always_comb begin
    if (stallreq || addr_err || (is_mem && !is_load))
      mem_wreg = 1'b0;
    else if (state_reg == S_DONE)
      mem_wreg = res_wreg_reg;
    else
      mem_wreg = ex_wreg;
  end

endmodule
